// File: rtl/uart_dtm.sv
// uart_dtm: UART-to-DMI debug transport; turns 6-byte command frames into one DMI request each
// and returns the 5-byte response frame {status, data[7:0], data[15:8], data[23:16], data[31:24]}.
// Ports: clk/rst_n (async active-low), rx/tx UART pins (idle high),
//        req_* DMI request channel, resp_* DMI response channel,
//        active high while a frame/transaction is in progress.
module uart_dtm #(
  parameter int ClkDiv       = 434,
  parameter int AddressWidth = 7,
  parameter int DataWidth    = 32,
  parameter int TimeoutBits  = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  output logic                    tx,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [1:0]              req_op,
  output logic [AddressWidth-1:0] req_addr,
  output logic [DataWidth-1:0]    req_data,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  input  logic [1:0]              resp_op,
  input  logic [DataWidth-1:0]    resp_data,
  output logic                    active
);
  localparam int CW = $clog2(ClkDiv);
  localparam int TL = TimeoutBits * ClkDiv;
  localparam int TW = $clog2(TL + 1);
  localparam logic [CW-1:0] BitMax  = CW'(ClkDiv - 1);
  localparam logic [CW-1:0] HalfMax = CW'(ClkDiv / 2 - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, REQ, WAIT, SEND} state_e;
  logic [2:0]              sync_q;
  logic                    rx_busy_q;
  logic [CW-1:0]           rx_cnt_q;
  logic [3:0]              rx_bit_q;
  logic [7:0]              rx_sh_q;
  state_e                  state_q;
  logic [2:0]              byte_q;
  logic [1:0]              op_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    data_q;
  logic                    req_valid_q, resp_ready_q, active_q, ovr_q;
  logic [TW-1:0]           to_q;
  logic [CW-1:0]           tx_cnt_q;
  logic [5:0]              tx_n_q;
  logic [49:0]             tx_sh_q;
  logic                    rx_s, rx_tick, rx_stb, rx_err, busy_st, load;
  logic [1:0]              ld_op;
  logic [DataWidth-1:0]    ld_data;
  logic [49:0]             tx_frame;
  always_comb begin
    rx_s     = sync_q[1];
    rx_tick  = rx_busy_q && rx_cnt_q == '0;
    rx_stb   = rx_tick && rx_bit_q == 4'd9 && rx_s;
    rx_err   = rx_tick && rx_bit_q == 4'd9 && !rx_s;
    busy_st  = state_q inside {REQ, WAIT, SEND};
    ld_op    = state_q == WAIT ? resp_op : 2'b00;
    ld_data  = state_q == WAIT ? resp_data : '0;
    // five 8N1 characters back to back, sent LSB first from bit 0
    tx_frame = {1'b1, ld_data[31:24], 1'b0, 1'b1, ld_data[23:16], 1'b0,
                1'b1, ld_data[15:8], 1'b0, 1'b1, ld_data[7:0], 1'b0,
                1'b1, ovr_q, 5'b0, ld_op, 1'b0};
    // nop/reserved ops skip the DMI and answer immediately on the 6th byte
    load     = (state_q == WAIT && resp_valid) ||
               (state_q == COLLECT && rx_stb && byte_q == 3'd5 && (op_q == 2'd0 || op_q == 2'd3));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 3'b111;
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx};
      if (!rx_busy_q) begin
        if (sync_q[2] && !sync_q[1]) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HalfMax;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= BitMax;
        rx_bit_q <= rx_bit_q + 4'd1;
        if ((rx_bit_q == 4'd0 && rx_s) || rx_bit_q == 4'd9) rx_busy_q <= 1'b0;
        if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_sh_q <= {rx_s, rx_sh_q[7:1]};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      active_q     <= 1'b0;
      ovr_q        <= 1'b0;
      to_q         <= '0;
      tx_cnt_q     <= '0;
      tx_n_q       <= '0;
      tx_sh_q      <= '1;
    end else begin
      case (state_q)
        IDLE: if (rx_stb) begin
          op_q     <= rx_sh_q[1:0];
          byte_q   <= 3'd1;
          active_q <= 1'b1;
          to_q     <= '0;
          state_q  <= COLLECT;
        end
        COLLECT: begin
          // only idle line time counts toward the inter-byte timeout
          to_q <= rx_busy_q ? '0 : to_q + 1'b1;
          if (rx_err || to_q == TW'(TL - 1)) begin
            state_q  <= IDLE;
            byte_q   <= '0;
            active_q <= 1'b0;
          end else if (rx_stb) begin
            byte_q <= byte_q + 3'd1;
            if (byte_q == 3'd1) addr_q <= rx_sh_q[AddressWidth-1:0];
            else data_q <= {rx_sh_q, data_q[DataWidth-1:8]};
            if (byte_q == 3'd5) begin
              byte_q <= '0;
              if (load) state_q <= SEND;
              else begin
                req_valid_q <= 1'b1;
                state_q     <= REQ;
              end
            end
          end
        end
        REQ: if (req_ready) begin
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: if (resp_valid) begin
          resp_ready_q <= 1'b0;
          state_q      <= SEND;
        end
        SEND: begin
          if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 1'b1;
          else if (tx_n_q == 6'd49) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else begin
            tx_n_q   <= tx_n_q + 6'd1;
            tx_sh_q  <= {1'b1, tx_sh_q[49:1]};
            tx_cnt_q <= BitMax;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load) begin
        tx_sh_q  <= tx_frame;
        tx_n_q   <= '0;
        tx_cnt_q <= BitMax;
        ovr_q    <= 1'b0;
      end
      // a byte landing on the load edge stays flagged for the next response
      if (rx_stb && busy_st) ovr_q <= 1'b1;
    end
  end
  assign tx         = tx_sh_q[0];
  assign req_valid  = req_valid_q;
  assign req_op     = op_q;
  assign req_addr   = addr_q;
  assign req_data   = data_q;
  assign resp_ready = resp_ready_q;
  assign active     = active_q;
endmodule

// File: tb/tb_uart_dtm.sv
// tb_uart_dtm: directed table-driven bench for uart_dtm with a UART driver/monitor and a DMI responder
module tb_uart_dtm;
  localparam int Div = 8;
  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tx;
  logic        req_valid, req_ready = 1'b0, resp_valid = 1'b0, resp_ready, active;
  logic [1:0]  req_op, resp_op = 2'd0;
  logic [6:0]  req_addr;
  logic [31:0] req_data, resp_data = 32'd0;
  always #5 clk = ~clk;
  uart_dtm #(.ClkDiv(Div), .AddressWidth(7), .DataWidth(32), .TimeoutBits(40)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_op(resp_op), .resp_data(resp_data), .active(active)
  );
  typedef struct packed {
    logic [47:0] b;
    logic [3:0]  rdly;
    logic [1:0]  rop;
    logic [31:0] rdata;
    logic [39:0] exp;
    logic        hs;
    logic [1:0]  eop;
    logic [6:0]  eaddr;
    logic [31:0] edata;
  } vec_t;
  vec_t vecs [7];
  int passed = 0, total = 0;
  int hs_cnt = 0, unstable = 0, stop_bad = 0;
  int ready_dly = 0, resp_dly = 3;
  logic hold_resp = 1'b0;
  logic [1:0] cfg_op = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic [1:0] hs_op;
  logic [6:0] hs_addr;
  logic [31:0] hs_data;
  logic [7:0] txq [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (Div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Div) @(negedge clk);
          b[i] = tx;
        end
        repeat (Div) @(negedge clk);
        if (tx !== 1'b1) stop_bad++;
        txq.push_back(b);
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        hs_op = req_op;
        hs_addr = req_addr;
        hs_data = req_data;
        for (int i = 0; i < ready_dly; i++) begin
          @(negedge clk);
          if (req_valid !== 1'b1 || req_op !== hs_op || req_addr !== hs_addr || req_data !== hs_data) unstable++;
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        hs_cnt++;
        if (req_valid !== 1'b0) unstable++;
        for (int n = 0; hold_resp && n < 5000; n++) @(negedge clk);
        repeat (resp_dly) @(negedge clk);
        if (resp_ready !== 1'b1) unstable++;
        resp_op = cfg_op;
        resp_data = cfg_data;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
      end
    end
  end
  task automatic send_byte(input logic [7:0] v, input logic bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (Div) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (Div) @(negedge clk);
    rx = 1'b1;
    repeat (2 * Div) @(negedge clk);
  endtask
  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[i*8 +: 8], 1'b0);
  endtask
  task automatic check_tx(input string tag, input logic [39:0] exp);
    for (int n = 0; txq.size() < 5 && n < 3000; n++) @(negedge clk);
    chk({tag, "_tx_count"}, 64'(txq.size()), 64'd5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("%s_tx_byte%0d", tag, j), j < txq.size() ? 64'(txq[j]) : 64'hFFFF, 64'(exp[j*8 +: 8]));
    for (int n = 0; active && n < 200; n++) @(negedge clk);
    chk({tag, "_active_end"}, 64'(active), 64'd0);
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    int hs0;
    ready_dly = int'(v.rdly);
    cfg_op = v.rop;
    cfg_data = v.rdata;
    hs0 = hs_cnt;
    txq.delete();
    send_frame(v.b);
    check_tx(tag, v.exp);
    chk({tag, "_handshakes"}, 64'(hs_cnt - hs0), 64'(v.hs));
    if (v.hs) begin
      chk({tag, "_req_op"}, 64'(hs_op), 64'(v.eop));
      chk({tag, "_req_addr"}, 64'(hs_addr), 64'(v.eaddr));
      chk({tag, "_req_data"}, 64'(hs_data), 64'(v.edata));
    end
  endtask
  initial begin
    int hs0;
    vecs[0] = '{48'h0000_0000_1001, 4'd0, 2'd0, 32'h12345678, 40'h12345678_00, 1'b1, 2'd1, 7'h10, 32'h0};
    vecs[1] = '{48'hDEAD_BEEF_0402, 4'd5, 2'd0, 32'hCAFEF00D, 40'hCAFEF00D_00, 1'b1, 2'd2, 7'h04, 32'hDEADBEEF};
    vecs[2] = '{48'h0000_0000_0501, 4'd0, 2'd3, 32'hA5A5A5A5, 40'hA5A5A5A5_03, 1'b1, 2'd1, 7'h05, 32'h0};
    vecs[3] = '{48'h4433_2211_7F02, 4'd2, 2'd2, 32'h00000000, 40'h00000000_02, 1'b1, 2'd2, 7'h7F, 32'h44332211};
    vecs[4] = '{48'h4433_2211_5500, 4'd0, 2'd0, 32'h0, 40'h0, 1'b0, 2'd0, 7'h0, 32'h0};
    vecs[5] = '{48'h0403_0201_83FF, 4'd0, 2'd0, 32'h0, 40'h0, 1'b0, 2'd0, 7'h0, 32'h0};
    vecs[6] = '{48'h0000_0000_93FD, 4'd1, 2'd0, 32'h00000001, 40'h00000001_00, 1'b1, 2'd1, 7'h13, 32'h0};
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_req_valid", 64'(req_valid), 64'd0);
    chk("reset_resp_ready", 64'(resp_ready), 64'd0);
    chk("reset_active", 64'(active), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    hold_resp = 1'b1;
    ready_dly = 0;
    cfg_op = 2'd2;
    cfg_data = 32'hAABBCCDD;
    hs0 = hs_cnt;
    txq.delete();
    send_frame(48'h0000_0000_2001);
    for (int n = 0; hs_cnt == hs0 && n < 2000; n++) @(negedge clk);
    chk("ovr_handshake", 64'(hs_cnt - hs0), 64'd1);
    send_byte(8'h99, 1'b0);
    hold_resp = 1'b0;
    check_tx("ovr", 40'hAABBCCDD_82);
    chk("ovr_single_hs", 64'(hs_cnt - hs0), 64'd1);
    run_vec("nop_after_ovr", '{48'hEEDD_CCBB_AA00, 4'd0, 2'd0, 32'h0, 40'h0, 1'b0, 2'd0, 7'h0, 32'h0});
    hs0 = hs_cnt;
    txq.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("ferr_active_before", 64'(active), 64'd1);
    send_byte(8'h00, 1'b1);
    chk("ferr_active_after", 64'(active), 64'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    chk("timeout_active_before", 64'(active), 64'd1);
    repeat (400) @(negedge clk);
    chk("timeout_active_after", 64'(active), 64'd0);
    chk("err_no_request", 64'(hs_cnt - hs0), 64'd0);
    chk("err_no_tx", 64'(txq.size()), 64'd0);
    run_vec("clean_after_err", vecs[0]);
    ready_dly = 0;
    cfg_op = 2'd0;
    cfg_data = 32'h0BADF00D;
    txq.delete();
    send_frame(vecs[0].b);
    for (int n = 0; txq.size() < 1 && n < 2000; n++) @(negedge clk);
    for (int n = 0; tx !== 1'b0 && n < 50; n++) @(negedge clk);
    chk("rst_mid_send_tx_low", 64'(tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 64'(tx), 64'd1);
    chk("rst_async_active", 64'(active), 64'd0);
    chk("rst_async_resp_ready", 64'(resp_ready), 64'd0);
    chk("rst_async_req_valid", 64'(req_valid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    txq.delete();
    run_vec("after_reset", vecs[1]);
    chk("tx_stop_bits", 64'(stop_bad), 64'd0);
    chk("req_stable", 64'(unstable), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
